keypad_scan: RTL and testbench
==============================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 1000, meaning clock cycles each column is driven before advancing.
REQ-002 The block SHALL have parameter DEBOUNCE_CNT, default 20000, meaning consecutive stable cycles required to accept a press or a release.
REQ-003 IN_clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 IN_reset  input  1  reset, asynchronous and active-low.
REQ-005 IN_row  input  4  keypad row lines, active-low, pulled high externally, asynchronous to IN_clk.
REQ-006 OUT_col  output  4  keypad column drive, active-low, exactly one bit low at all times.
REQ-007 OUT_value  output  4  code of the last accepted key, equal to 4*row_index + col_index.
REQ-008 OUT_key  output  1  one-cycle strobe marking a new accepted press, consumed by the expression-entry stage as its key strobe.
REQ-009 OUT_pressed  output  1  high from the accepted press until the accepted release.

Function
REQ-010 IN_row SHALL pass through a two-flop synchronizer; all decisions SHALL use the synchronized value (srow).
REQ-011 The FSM SHALL have states SCAN, DEBOUNCE, PRESS, HOLD and RELEASE.
REQ-012 SCAN: OUT_col drives column c low for SCAN_DIV cycles, then advances to c+1, wrapping from 3 to 0.
REQ-013 SCAN: on the last dwell cycle of column c, if srow != 4'hF, the FSM SHALL latch c and row r, go to DEBOUNCE and freeze OUT_col.
REQ-014 If several srow bits are low, r SHALL be the lowest-indexed low bit.
REQ-015 DEBOUNCE: the counter increments each cycle while srow[r] is low; if srow[r] goes high, the counter clears and the FSM returns to SCAN, resuming at column c+1 (mod 4).
REQ-016 DEBOUNCE: when the counter reaches DEBOUNCE_CNT-1 with srow[r] still low, the FSM SHALL go to PRESS.
REQ-017 PRESS: lasts exactly one cycle; OUT_key=1, OUT_value=4*r+c and OUT_pressed=1 are registered in that cycle; next state is HOLD.
REQ-018 HOLD: OUT_col stays frozen and no strobes are issued; when srow[r] goes high, the counter clears and the FSM goes to RELEASE.
REQ-019 RELEASE: the counter increments while srow[r] is high; any low cycle clears it and returns the FSM to HOLD; at DEBOUNCE_CNT-1 the FSM clears OUT_pressed and goes to SCAN at column c+1 (mod 4).
REQ-020 OUT_key SHALL be high only in PRESS, so each physical press gives exactly one strobe regardless of hold time.
REQ-021 OUT_value SHALL hold its value between presses and change only in PRESS.
REQ-022 Keys in other rows or columns SHALL be ignored in DEBOUNCE, HOLD and RELEASE.
REQ-023 Counters SHALL be wide enough for max(SCAN_DIV, DEBOUNCE_CNT) and SHALL NOT wrap.
REQ-024 Latency SHALL be DEBOUNCE_CNT+1 cycles from the detecting sample (REQ-013) to OUT_key high.

Reset
REQ-025 While IN_reset=0 the block SHALL immediately force: state=SCAN, column 0, OUT_col=4'b1110, OUT_key=0, OUT_value=4'h0, OUT_pressed=0, all counters 0 and synchronizer flops 4'hF.
REQ-026 Reset asserted in any state, including DEBOUNCE or PRESS, SHALL suppress any pending strobe.
REQ-027 After reset release, scanning SHALL start at column 0 with a full SCAN_DIV dwell.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=8; the bench keypad model drives IN_row[r] low iff key (r,c) is held and OUT_col[c]=0)
REQ-028 Reset: assert IN_reset=0 mid-scan -> OUT_col=4'b1110, OUT_key=0, OUT_value=0 and OUT_pressed=0 without waiting for a clock.
REQ-029 Single press: hold key (2,1) for 200 cycles -> exactly one OUT_key pulse with OUT_value=4'h9; OUT_pressed stays high until 8 stable cycles after release; then OUT_col resumes rotation from column 2.
REQ-030 Bounce reject: pull row 0 low for 3 cycles in column 3 -> no OUT_key, state returns to SCAN, OUT_value unchanged.
REQ-031 Multi-key: hold (1,3) and (3,3) together -> one pulse with OUT_value=4'h7.
REQ-032 Release bounce: after an accepted press of (0,0), release with 3-cycle low glitches, then press (0,0) again cleanly -> exactly two OUT_key pulses in total, both OUT_value=4'h0.
REQ-033 Reset in DEBOUNCE: hold (3,2), assert reset at debounce count 5 -> no OUT_key pulse; after release of reset the key is re-detected and one pulse with OUT_value=4'hE follows.

Source files
------------

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: rotates an active-low column drive, debounces the
// first key found on a column, and reports its code with a single-cycle strobe.
module keypad_scan #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic       IN_clk,
    input  logic       IN_reset,
    input  logic [3:0] IN_row,
    output logic [3:0] OUT_col,
    output logic [3:0] OUT_value,
    output logic       OUT_key,
    output logic       OUT_pressed,
    output logic [2:0] OUT_state
);

    localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CNT - 1);

    // OUT_state encoding: 0 SCAN, 1 DEBOUNCE, 2 PRESS, 3 HOLD, 4 RELEASE
    typedef enum logic [2:0] {
        SCAN     = 3'd0,
        DEBOUNCE = 3'd1,
        PRESS    = 3'd2,
        HOLD     = 3'd3,
        RELEASE  = 3'd4
    } state_t;

    state_t        state;
    logic [3:0]    sync1;
    logic [3:0]    srow;
    logic [1:0]    col;
    logic [1:0]    row;
    logic [1:0]    col_next;
    logic [1:0]    low_row;
    logic          row_low;
    logic [CW-1:0] scan_cnt;
    logic [CW-1:0] deb_cnt;

    function automatic logic [3:0] col_drive(input logic [1:0] c);
        return ~(4'b0001 << c);
    endfunction

    // Lowest-indexed active row wins when several keys share a column.
    always_comb begin
        low_row = 2'd3;
        if (!srow[0])      low_row = 2'd0;
        else if (!srow[1]) low_row = 2'd1;
        else if (!srow[2]) low_row = 2'd2;
    end

    assign col_next  = col + 2'd1;
    assign row_low   = ~srow[row];
    assign OUT_state = state;

    always_ff @(posedge IN_clk or negedge IN_reset) begin
        if (!IN_reset) begin
            state       <= SCAN;
            sync1       <= 4'hF;
            srow        <= 4'hF;
            col         <= 2'd0;
            row         <= 2'd0;
            scan_cnt    <= '0;
            deb_cnt     <= '0;
            OUT_col     <= 4'b1110;
            OUT_value   <= 4'h0;
            OUT_key     <= 1'b0;
            OUT_pressed <= 1'b0;
        end else begin
            sync1   <= IN_row;
            srow    <= sync1;
            OUT_key <= 1'b0;
            case (state)
                SCAN: begin
                    if (scan_cnt == SCAN_LAST) begin
                        scan_cnt <= '0;
                        if (srow != 4'hF) begin
                            row     <= low_row;
                            deb_cnt <= '0;
                            state   <= DEBOUNCE;
                        end else begin
                            col     <= col_next;
                            OUT_col <= col_drive(col_next);
                        end
                    end else begin
                        scan_cnt <= scan_cnt + CW'(1);
                    end
                end
                DEBOUNCE: begin
                    if (row_low) begin
                        if (deb_cnt == DEB_LAST) begin
                            deb_cnt <= '0;
                            state   <= PRESS;
                        end else begin
                            deb_cnt <= deb_cnt + CW'(1);
                        end
                    end else begin
                        // Bounce: give up on this column and carry on from the next.
                        deb_cnt <= '0;
                        col     <= col_next;
                        OUT_col <= col_drive(col_next);
                        state   <= SCAN;
                    end
                end
                PRESS: begin
                    OUT_key     <= 1'b1;
                    OUT_value   <= {row, col};
                    OUT_pressed <= 1'b1;
                    state       <= HOLD;
                end
                HOLD: begin
                    if (!row_low) begin
                        deb_cnt <= '0;
                        state   <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (row_low) begin
                        deb_cnt <= '0;
                        state   <= HOLD;
                    end else if (deb_cnt == DEB_LAST) begin
                        deb_cnt     <= '0;
                        OUT_pressed <= 1'b0;
                        col         <= col_next;
                        OUT_col     <= col_drive(col_next);
                        state       <= SCAN;
                    end else begin
                        deb_cnt <= deb_cnt + CW'(1);
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a keypad matrix model, a strobe scoreboard and
// directed plus randomized press/bounce/reset scenarios.
module tb_keypad_scan;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 8;
    localparam int LAT      = SCAN_DIV + DEB + 1;

    logic       IN_clk = 1'b0;
    logic       IN_reset;
    logic [3:0] IN_row;
    logic [3:0] OUT_col;
    logic [3:0] OUT_value;
    logic       OUT_key;
    logic       OUT_pressed;
    logic [2:0] OUT_state;

    int         total = 0;
    int         bad = 0;
    int         cycle = 0;
    int         last_col_cycle = 0;
    bit         lat_valid = 1'b0;
    logic [3:0] prev_col = 4'b1110;
    logic [3:0] exp_q[$];
    logic [3:0] held[4];
    logic [3:0] glitch;

    keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEB)) dut (
        .IN_clk(IN_clk), .IN_reset(IN_reset), .IN_row(IN_row),
        .OUT_col(OUT_col), .OUT_value(OUT_value), .OUT_key(OUT_key),
        .OUT_pressed(OUT_pressed), .OUT_state(OUT_state)
    );

    // clock / reset
    always #5 IN_clk = ~IN_clk;
    always @(posedge IN_clk) cycle <= cycle + 1;

    // keypad matrix: row r pulled low iff a held key (r,c) sits on the driven column
    always_comb begin
        IN_row = 4'hF;
        for (int r = 0; r < 4; r++)
            IN_row[r] = ~(|(held[r] & ~OUT_col)) & ~glitch[r];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // scoreboard: every strobe must match the oldest expected code
    always @(negedge IN_clk) begin
        if (!IN_reset) begin
            lat_valid <= 1'b0;
            prev_col  <= OUT_col;
        end else begin
            check("col_onehot", $countones(~OUT_col), 1);
            if (OUT_col !== prev_col) begin
                last_col_cycle <= cycle;
                lat_valid      <= 1'b1;
            end
            prev_col <= OUT_col;
            if (OUT_key === 1'b1) begin
                check("strobe_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check("key_value", OUT_value, exp_q.pop_front());
                check("key_pressed", OUT_pressed, 1);
                if (lat_valid) check("key_latency", cycle - last_col_cycle, LAT);
            end
        end
    end

    // driver tasks
    task automatic ticks(input int n);
        repeat (n) @(negedge IN_clk);
    endtask

    task automatic release_all();
        for (int r = 0; r < 4; r++) held[r] = 4'h0;
    endtask

    task automatic wait_col(input logic [3:0] target);
        int n;
        n = 0;
        while (OUT_col === target && n < 64) begin @(negedge IN_clk); n++; end
        n = 0;
        while (OUT_col !== target && n < 64) begin @(negedge IN_clk); n++; end
        check("wait_col", OUT_col, target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, c, gr, gc, hold, lowest;
        IN_reset = 1'b0;
        glitch   = 4'h0;
        release_all();

        // reset state, then first full column-0 dwell and rotation
        ticks(3);
        check("rst_col", OUT_col, 4'b1110);
        check("rst_key", OUT_key, 0);
        check("rst_value", OUT_value, 0);
        check("rst_pressed", OUT_pressed, 0);
        check("rst_state", OUT_state, 0);
        IN_reset = 1'b1;
        ticks(3);
        check("dwell0", OUT_col, 4'b1110);
        ticks(1);
        check("advance1", OUT_col, 4'b1101);
        ticks(4);
        check("advance2", OUT_col, 4'b1011);

        // single press (2,1) held 200 cycles
        exp_q.push_back(4'(4 * 2 + 1));
        held[2][1] = 1'b1;
        ticks(200);
        check("single_pressed", OUT_pressed, 1);
        check("single_value", OUT_value, 4'h9);
        held[2][1] = 1'b0;
        ticks(10);
        check("single_hold_after_release", OUT_pressed, 1);
        ticks(2);
        check("single_released", OUT_pressed, 0);
        check("single_resume_col2", OUT_col, 4'b1011);
        check("single_count", exp_q.size(), 0);

        // asynchronous reset mid-scan
        @(posedge IN_clk);
        #2 IN_reset = 1'b0;
        #1;
        check("async_rst_col", OUT_col, 4'b1110);
        check("async_rst_key", OUT_key, 0);
        check("async_rst_value", OUT_value, 0);
        check("async_rst_pressed", OUT_pressed, 0);
        @(negedge IN_clk);
        IN_reset = 1'b1;

        // two keys on column 3: lowest row wins
        held[1][3] = 1'b1;
        held[3][3] = 1'b1;
        lowest = 4;
        for (int k = 3; k >= 0; k--) if (held[k][3]) lowest = k;
        exp_q.push_back(4'(4 * lowest + 3));
        ticks(80);
        release_all();
        ticks(30);
        check("multi_value", OUT_value, 4'h7);
        check("multi_pressed", OUT_pressed, 0);
        check("multi_count", exp_q.size(), 0);

        // 3-cycle low on row 0 during column 3 must be rejected
        wait_col(4'b0111);
        ticks(1);
        glitch[0] = 1'b1;
        ticks(3);
        glitch[0] = 1'b0;
        ticks(1);
        check("bounce_frozen", OUT_col, 4'b0111);
        ticks(3);
        check("bounce_resume_col0", OUT_col, 4'b1110);
        check("bounce_state_scan", OUT_state, 0);
        check("bounce_value", OUT_value, 4'h7);
        check("bounce_count", exp_q.size(), 0);

        // release bounce on (0,0), then a clean second press
        exp_q.push_back(4'h0);
        held[0][0] = 1'b1;
        ticks(60);
        check("relb_pressed", OUT_pressed, 1);
        for (int i = 0; i < 2; i++) begin
            held[0][0] = 1'b0;
            ticks(3);
            held[0][0] = 1'b1;
            ticks(3);
        end
        check("relb_still_pressed", OUT_pressed, 1);
        held[0][0] = 1'b0;
        ticks(30);
        check("relb_released", OUT_pressed, 0);
        check("relb_one_so_far", exp_q.size(), 0);
        exp_q.push_back(4'h0);
        held[0][0] = 1'b1;
        ticks(60);
        held[0][0] = 1'b0;
        ticks(30);
        check("relb_value", OUT_value, 4'h0);
        check("relb_count", exp_q.size(), 0);

        // reset at debounce count 5 while (3,2) is held
        wait_col(4'b1101);
        held[3][2] = 1'b1;
        wait_col(4'b1011);
        ticks(9);
        #1 IN_reset = 1'b0;
        #1;
        check("deb_rst_key", OUT_key, 0);
        check("deb_rst_col", OUT_col, 4'b1110);
        check("deb_rst_pressed", OUT_pressed, 0);
        ticks(3);
        check("deb_rst_key_hold", OUT_key, 0);
        IN_reset = 1'b1;
        exp_q.push_back(4'hE);
        ticks(80);
        held[3][2] = 1'b0;
        ticks(30);
        check("deb_rst_value", OUT_value, 4'hE);
        check("deb_rst_count", exp_q.size(), 0);

        // randomized presses, each preceded by a short glitch on a random key
        for (int it = 0; it < 12; it++) begin
            gr = $urandom_range(0, 3);
            gc = $urandom_range(0, 3);
            held[gr][gc] = 1'b1;
            ticks($urandom_range(1, 3));
            held[gr][gc] = 1'b0;
            ticks(6);
            r    = $urandom_range(0, 3);
            c    = $urandom_range(0, 3);
            hold = $urandom_range(50, 120);
            exp_q.push_back(4'(4 * r + c));
            held[r][c] = 1'b1;
            ticks(hold);
            held[r][c] = 1'b0;
            ticks(30);
            check("rand_value", OUT_value, 32'(4 * r + c));
            check("rand_released", OUT_pressed, 0);
        end

        check("final_pending", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
